// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut
//   Sprite colour palette. It holds DEPTH = 2**IDX_W colour words and is
//   filled with DEFAULT_COLOR by a sequential initialisation pass. Pixel
//   indices are looked up through a 2-stage pipeline with no stall. Palette
//   entries are written through a valid/ready handshake, and only in RUN.
//
//   Optional feature: define PAL_TRANSPARENCY_EN to add the pix_transp_o
//   flag. The flag is raised for pixels whose index equals TRANSP_IDX.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   soft_init_i    one-cycle pulse; restarts palette initialisation
//   pix_valid_i    pixel index qualifier
//   pix_idx_i      palette index to look up
//   pix_valid_o    output colour qualifier (2 cycles after pix_valid_i)
//   pix_color_o    looked-up colour; holds its value while pix_valid_o is low
//   pix_transp_o   transparent-pixel flag (PAL_TRANSPARENCY_EN only)
//   wr_valid_i     palette write request
//   wr_ready_o     write acceptance; high only in RUN
//   wr_idx_i       entry to write
//   wr_color_i     colour to write
//   init_busy_o    high while initialisation is in progress
module sprite_palette_lut #(
  parameter int                 IDX_W         = 5,
  parameter int                 COLOR_W       = 24,
  parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 24'hFFFFFF,
  parameter int                 TRANSP_IDX    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_init_i,
  input  logic               pix_valid_i,
  input  logic [IDX_W-1:0]   pix_idx_i,
  output logic               pix_valid_o,
  output logic [COLOR_W-1:0] pix_color_o,
`ifdef PAL_TRANSPARENCY_EN
  output logic               pix_transp_o,
`endif
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [COLOR_W-1:0] wr_color_i,
  output logic               init_busy_o
);

  localparam int               DEPTH    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_cnt;
  logic [COLOR_W-1:0] palette [DEPTH];
  logic               wr_fire;
  logic [COLOR_W-1:0] lookup_color;
  logic               s1_valid;
  logic [COLOR_W-1:0] s1_color;

  assign wr_ready_o  = (state == RUN);
  assign init_busy_o = (state == INIT);
  assign wr_fire     = wr_valid_i & wr_ready_o;

  // INIT sweeps the counter over every entry, one entry per cycle, and then
  // hands over to RUN. When the counter wraps it does not re-enter INIT.
  // Only soft_init_i can restart the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (soft_init_i) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_IDX) begin
        state <= RUN;
      end
    end
  end

  // The storage is not reset. Its contents are defined once INIT completes,
  // and lookups made before that point return DEFAULT_COLOR.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      palette[init_cnt] <= DEFAULT_COLOR;
    end else if (wr_fire) begin
      palette[wr_idx_i] <= wr_color_i;
    end
  end

  // A write accepted in the same cycle as a lookup of the same index is
  // forwarded, so the pixel sees the new colour rather than the stale one.
  always_comb begin
    lookup_color = palette[pix_idx_i];
    if (state == INIT) begin
      lookup_color = DEFAULT_COLOR;
    end else if (wr_fire && (wr_idx_i == pix_idx_i)) begin
      lookup_color = wr_color_i;
    end
  end

  // Two register stages. The colour registers load only with a valid pixel,
  // so pix_color_o holds its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_color    <= '0;
      pix_valid_o <= 1'b0;
      pix_color_o <= '0;
    end else begin
      s1_valid    <= pix_valid_i;
      pix_valid_o <= s1_valid;
      if (pix_valid_i) begin
        s1_color <= lookup_color;
      end
      if (s1_valid) begin
        pix_color_o <= s1_color;
      end
    end
  end

`ifdef PAL_TRANSPARENCY_EN
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

  logic s1_transp;

  // The transparency flag travels with the pixel and is qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_transp    <= 1'b0;
      pix_transp_o <= 1'b0;
    end else begin
      s1_transp    <= pix_valid_i && (pix_idx_i == TRANSP);
      pix_transp_o <= s1_valid && s1_transp;
    end
  end
`endif

endmodule

// File: doc/sprite_palette_lut.md
SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

Interface
REQ-001 Parameter IDX_W, default 5, SHALL set the palette index width; DEPTH = 2**IDX_W entries.
REQ-002 Parameter COLOR_W, default 24, SHALL set the colour word width (RGB888 at default).
REQ-003 Parameter DEFAULT_COLOR, default 24'hFFFFFF, SHALL set the colour loaded into every entry by initialisation.
REQ-004 Parameter TRANSP_IDX, default 0, SHALL set the index flagged as transparent.
REQ-005 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 soft_init_i  input  1  one-cycle pulse that restarts palette initialisation.
REQ-008 pix_valid_i  input  1  pixel index qualifier.
REQ-009 pix_idx_i  input  IDX_W  palette index to look up.
REQ-010 pix_valid_o  output  1  output colour qualifier.
REQ-011 pix_color_o  output  COLOR_W  looked-up colour.
REQ-012 pix_transp_o  output  1  transparent-pixel flag (present only with PAL_TRANSPARENCY_EN).
REQ-013 wr_valid_i  input  1  palette write request.
REQ-014 wr_ready_o  output  1  write acceptance; a write SHALL occur when wr_valid_i and wr_ready_o are both high.
REQ-015 wr_idx_i  input  IDX_W  entry to write.
REQ-016 wr_color_i  input  COLOR_W  colour to write.
REQ-017 init_busy_o  output  1  high while initialisation is in progress.

Function
REQ-018 Palette storage SHALL be DEPTH x COLOR_W registers/RAM; writes SHALL occur only via the handshake or initialisation.
REQ-019 FSM SHALL have two states: INIT and RUN.
- INIT: an IDX_W-bit counter SHALL write DEFAULT_COLOR to entries 0..DEPTH-1, one per cycle.
- INIT -> RUN SHALL occur the cycle after entry DEPTH-1 is written (INIT lasts exactly DEPTH cycles).
- RUN -> INIT SHALL occur when soft_init_i is high; the counter restarts at 0.
- soft_init_i during INIT SHALL restart the counter at 0.
REQ-020 wr_ready_o SHALL be high in RUN and low in INIT; init_busy_o SHALL equal (state == INIT).
REQ-021 Pixel path SHALL be a 2-stage pipeline: pix_valid_o and pix_color_o SHALL reflect pix_valid_i/pix_idx_i sampled two cycles earlier, one result per cycle, with no stall.
REQ-022 While pix_valid_o is low, pix_color_o SHALL hold its previous value.
REQ-023 Lookups sampled while in INIT SHALL return DEFAULT_COLOR with pix_valid_o asserted normally.
REQ-024 A write accepted in the same cycle the pixel stage samples the same index SHALL be bypassed: the lookup returns wr_color_i.
REQ-025 A write to index k SHALL affect only entry k; out-of-range indices cannot occur because DEPTH = 2**IDX_W.
REQ-026 Counter wrap from DEPTH-1 SHALL NOT re-enter INIT unless soft_init_i is asserted.

Reset
REQ-027 While rst_n is low: state = INIT, counter = 0, pix_valid_o = 0, pix_color_o = 0, pix_transp_o = 0, wr_ready_o = 0, init_busy_o = 1.
REQ-028 Assertion of rst_n mid-operation SHALL abort any write or pipeline contents immediately; initialisation SHALL start on the first edge after release.
REQ-029 Palette contents need not be reset directly; they are defined only after INIT completes.

Configuration
REQ-030 With macro PAL_TRANSPARENCY_EN defined, pix_transp_o SHALL exist and be high with pix_valid_o when the pipelined index equals TRANSP_IDX, else low.
REQ-031 Without PAL_TRANSPARENCY_EN, the pix_transp_o port and its pipeline register SHALL NOT exist; all other behaviour is unchanged.

Verification
REQ-032 Reset release, defaults: INIT lasts 32 cycles; init_busy_o falls at cycle 32; a lookup of idx 7 then returns 24'hFFFFFF two cycles later.
REQ-033 Write 0x582818 to idx 1 in RUN, then look up idx 1 -> pix_color_o = 24'h582818 with latency 2.
REQ-034 Same-cycle write 0x4078D8 to idx 8 plus lookup of idx 8 -> 24'h4078D8 (bypass).
REQ-035 soft_init_i at INIT count 10 -> counter restarts; init_busy_o stays high 32 more cycles; idx 1 reads 24'hFFFFFF afterwards.
REQ-036 PAL_TRANSPARENCY_EN defined, streaming indices 0,1,0 -> pix_transp_o = 1,0,1 aligned with pix_valid_o.
REQ-037 rst_n asserted during a pixel burst -> pix_valid_o = 0 and wr_ready_o = 0 asynchronously, before the next clock edge.
